// File: rtl/ethertype_dispatcher.sv
// Routes Ethernet frame payloads to an IPv4 or ARP decoder by destination MAC and ethertype;
// frames that do not match are consumed and dropped. Forward and drop counts saturate.
module ethertype_dispatcher #(
   parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
   parameter logic [15:0] TYPE_IPV4 = 16'h0800,
   parameter logic [15:0] TYPE_ARP  = 16'h0806
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hdr_valid,
   input  logic [47:0] hdr_dst_mac,
   input  logic [47:0] hdr_src_mac,
   input  logic [15:0] hdr_ethertype,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_last,
   input  logic        rx_err,
   output logic        rx_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        out_err,
   output logic [1:0]  out_valid,
   input  logic [1:0]  out_ready,
   output logic [47:0] out_src_mac,
   output logic [15:0] cnt_fwd,
   output logic [15:0] cnt_drop,
   output logic        hdr_overrun
);

   localparam int unsigned MAC_W = 48;
   localparam int unsigned CNT_W = 16;
   localparam logic [MAC_W-1:0] BCAST_MAC = '1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

   state_t state, state_nxt;
   logic   sel;
   logic   hdr_match;
   logic   fwd_done;
   logic   drop_done;

   assign hdr_match = ((hdr_dst_mac == LOCAL_MAC) || (hdr_dst_mac == BCAST_MAC)) &&
                      ((hdr_ethertype == TYPE_IPV4) || (hdr_ethertype == TYPE_ARP));

   // Payload bus is a zero-latency pass-through; only valid/ready are steered.
   assign out_data = rx_data;
   assign out_last = rx_last;
   assign out_err  = rx_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      out_valid = 2'b00;
      fwd_done  = 1'b0;
      drop_done = 1'b0;
      case (state)
         IDLE: begin
            if (hdr_valid) begin
               state_nxt = hdr_match ? FORWARD : DROP;
            end
         end
         FORWARD: begin
            rx_ready       = out_ready[sel];
            out_valid[sel] = rx_valid;
            if (rx_valid && out_ready[sel] && rx_last) begin
               fwd_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         DROP: begin
            rx_ready = 1'b1;
            if (rx_valid && rx_last) begin
               drop_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame context is captured only for accepted headers seen in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel         <= 1'b0;
         out_src_mac <= '0;
      end else if ((state == IDLE) && hdr_valid && hdr_match) begin
         sel         <= (hdr_ethertype == TYPE_ARP);
         out_src_mac <= hdr_src_mac;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_fwd <= '0;
      end else if (fwd_done && (cnt_fwd != CNT_MAX)) begin
         cnt_fwd <= cnt_fwd + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_drop <= '0;
      end else if (drop_done && (cnt_drop != CNT_MAX)) begin
         cnt_drop <= cnt_drop + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hdr_overrun <= 1'b0;
      end else if (hdr_valid && (state != IDLE)) begin
         hdr_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ethertype_dispatcher.sv
// Randomized bench for ethertype_dispatcher; a frame-level reference model predicts routing,
// handshakes, payload order, counters and the overrun flag.
module tb_ethertype_dispatcher;

   localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_01;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        hdr_valid;
   logic [47:0] hdr_dst_mac;
   logic [47:0] hdr_src_mac;
   logic [15:0] hdr_ethertype;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_last;
   logic        rx_err;
   logic        rx_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic        out_err;
   logic [1:0]  out_valid;
   logic [1:0]  out_ready;
   logic [47:0] out_src_mac;
   logic [15:0] cnt_fwd;
   logic [15:0] cnt_drop;
   logic        hdr_overrun;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_fwd;
   logic [15:0] m_drop;
   logic [47:0] m_src;
   logic        m_ovr;

   ethertype_dispatcher dut (
      .clk(clk), .reset(reset),
      .hdr_valid(hdr_valid), .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
      .hdr_ethertype(hdr_ethertype),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_err(rx_err),
      .rx_ready(rx_ready),
      .out_data(out_data), .out_last(out_last), .out_err(out_err),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_src_mac(out_src_mac), .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop),
      .hdr_overrun(hdr_overrun)
   );

   always #5 clk = ~clk;

   function automatic bit is_match(input logic [47:0] dst, input logic [15:0] typ);
      return ((dst == LMAC) || (dst == BCAST)) && ((typ == 16'h0800) || (typ == 16'h0806));
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic drive_idle_inputs();
      hdr_valid = 1'b0; hdr_dst_mac = '0; hdr_src_mac = '0; hdr_ethertype = '0;
      rx_data = '0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0; out_ready = 2'b00;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      drive_idle_inputs();
      m_fwd = '0; m_drop = '0; m_src = '0; m_ovr = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Sends one header plus payload. mode: 0 ready=11, 1 toggle ready[sel], 2 random.
   // ovr_beat >= 0 injects a second (matching) header on that beat with its beat forced valid.
   task automatic run_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                            input int len, input int mode, input bit gaps, input int ovr_beat);
      logic [7:0] q[$];
      int  idx, cyc;
      bit  fwd, s, tog, inj, err;
      logic       exp_rdy;
      logic [1:0] exp_ov;
      fwd = is_match(dst, typ);
      s   = (typ == 16'h0806);
      err = 1'($urandom);
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      @(negedge clk);
      hdr_valid = 1'b1; hdr_dst_mac = dst; hdr_src_mac = src; hdr_ethertype = typ;
      rx_valid = 1'b1; rx_data = q[0]; rx_last = (len == 1); out_ready = 2'b11;
      #1;
      n_cmp++;
      if (rx_ready !== 1'b0 || out_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_handshake: rx_ready=%b out_valid=%b want 0/00", rx_ready, out_valid);
      end
      if (fwd) m_src = src;
      @(negedge clk);
      idx = 0; cyc = 0; tog = 1'b0; inj = 1'b0;
      while (idx < len && cyc < 300) begin
         hdr_valid = 1'b0;
         rx_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (!inj && idx == ovr_beat) begin
            rx_valid = 1'b1; hdr_valid = 1'b1; hdr_dst_mac = LMAC;
            hdr_src_mac = ~src; hdr_ethertype = 16'h0800;
            inj = 1'b1; m_ovr = 1'b1;
         end
         rx_data = q[idx];
         rx_last = (idx == len - 1);
         rx_err  = err && (idx == len - 1);
         tog = ~tog;
         case (mode)
            0: out_ready = 2'b11;
            1: begin out_ready = 2'($urandom); out_ready[s] = tog; end
            default: out_ready = 2'($urandom);
         endcase
         #1;
         exp_rdy = fwd ? out_ready[s] : 1'b1;
         exp_ov  = (fwd && rx_valid) ? (s ? 2'b10 : 2'b01) : 2'b00;
         n_cmp++;
         if (rx_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL rx_ready beat%0d: got %b want %b", idx, rx_ready, exp_rdy);
         end
         n_cmp++;
         if (out_valid !== exp_ov) begin
            n_bad++;
            $display("FAIL out_valid beat%0d: got %b want %b", idx, out_valid, exp_ov);
         end
         if (fwd && rx_valid) begin
            n_cmp++;
            if ({out_data, out_last, out_err} !== {q[idx], idx == len - 1, err && (idx == len - 1)}) begin
               n_bad++;
               $display("FAIL payload beat%0d: got %h/%b/%b want %h/%b/%b", idx, out_data, out_last,
                        out_err, q[idx], idx == len - 1, err && (idx == len - 1));
            end
         end
         if (rx_valid && exp_rdy) idx++;
         cyc++;
         @(negedge clk);
      end
      if (idx < len) begin
         n_cmp++; n_bad++;
         $display("FAIL frame_timeout: delivered %0d beats want %0d", idx, len);
      end
      hdr_valid = 1'b0; rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
      if (fwd) m_fwd = sat_inc(m_fwd);
      else     m_drop = sat_inc(m_drop);
      #1;
      n_cmp++;
      if (rx_ready !== 1'b0 || out_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL back_to_idle: rx_ready=%b out_valid=%b want 0/00", rx_ready, out_valid);
      end
      n_cmp++;
      if (cnt_fwd !== m_fwd || cnt_drop !== m_drop) begin
         n_bad++;
         $display("FAIL counters: fwd=%h drop=%h want %h/%h", cnt_fwd, cnt_drop, m_fwd, m_drop);
      end
      n_cmp++;
      if (out_src_mac !== m_src) begin
         n_bad++;
         $display("FAIL out_src_mac: got %h want %h", out_src_mac, m_src);
      end
      n_cmp++;
      if (hdr_overrun !== m_ovr) begin
         n_bad++;
         $display("FAIL hdr_overrun: got %b want %b", hdr_overrun, m_ovr);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive_idle_inputs();
      m_fwd = '0; m_drop = '0; m_src = '0; m_ovr = 1'b0;
      repeat (2) @(negedge clk);
      hdr_valid = 1'b1; hdr_dst_mac = LMAC; hdr_ethertype = 16'h0800; hdr_src_mac = 48'h1234;
      @(negedge clk);
      hdr_valid = 1'b0;
      #1;
      n_cmp++;
      if ({rx_ready, out_valid, out_src_mac, cnt_fwd, cnt_drop, hdr_overrun} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: rx_ready=%b out_valid=%b src=%h fwd=%h drop=%h ovr=%b want all 0",
                  rx_ready, out_valid, out_src_mac, cnt_fwd, cnt_drop, hdr_overrun);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_ipv4_local();
      run_frame(LMAC, 48'hA1A2_A3A4_A5A6, 16'h0800, 4, 0, 1'b0, -1);
   endtask

   task automatic test_arp_broadcast();
      run_frame(BCAST, 48'hB1B2_B3B4_B5B6, 16'h0806, 6, 1, 1'b1, -1);
   endtask

   task automatic test_drop_unicast();
      run_frame(48'h02_00_00_00_00_02, 48'hC1C2_C3C4_C5C6, 16'h0800, 3, 2, 1'b0, -1);
   endtask

   task automatic test_random_frames();
      logic [47:0] dst;
      logic [15:0] typ;
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 2))
            0: dst = LMAC;
            1: dst = BCAST;
            default: dst = 48'({$urandom, $urandom});
         endcase
         case ($urandom_range(0, 3))
            0: typ = 16'h0800;
            1: typ = 16'h0806;
            2: typ = 16'h86DD;
            default: typ = 16'($urandom);
         endcase
         run_frame(dst, 48'({$urandom, $urandom}), typ, $urandom_range(1, 8),
                   $urandom_range(0, 2), 1'($urandom), -1);
      end
   endtask

   task automatic test_overrun_drop();
      run_frame(LMAC, 48'hD1D2_D3D4_D5D6, 16'h86DD, 6, 2, 1'b1, 2);
   endtask

   task automatic test_overrun_last();
      apply_reset();
      run_frame(LMAC, 48'hE1E2_E3E4_E5E6, 16'h0800, 4, 0, 1'b0, 3);
   endtask

   task automatic test_saturation();
      @(negedge clk);
      force dut.cnt_drop = 16'hFFFF;
      force dut.cnt_fwd  = 16'hFFFF;
      @(negedge clk);
      release dut.cnt_drop;
      release dut.cnt_fwd;
      m_drop = 16'hFFFF; m_fwd = 16'hFFFF;
      run_frame(48'h02_00_00_00_00_09, 48'h1111_2222_3333, 16'h0800, 2, 2, 1'b1, -1);
      run_frame(LMAC, 48'h4444_5555_6666, 16'h0806, 3, 2, 1'b1, -1);
   endtask

   task automatic test_reset_mid_frame();
      @(negedge clk);
      hdr_valid = 1'b1; hdr_dst_mac = LMAC; hdr_src_mac = 48'h7777_8888_9999; hdr_ethertype = 16'h0800;
      @(negedge clk);
      hdr_valid = 1'b0; rx_valid = 1'b1; rx_data = 8'h5A; rx_last = 1'b0; out_ready = 2'b11;
      #1;
      n_cmp++;
      if (out_valid !== 2'b01) begin
         n_bad++;
         $display("FAIL midframe_forward: out_valid=%b want 01", out_valid);
      end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({rx_ready, out_valid, out_src_mac, cnt_fwd, cnt_drop, hdr_overrun} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: rx_ready=%b out_valid=%b src=%h fwd=%h drop=%h ovr=%b want all 0",
                  rx_ready, out_valid, out_src_mac, cnt_fwd, cnt_drop, hdr_overrun);
      end
      m_fwd = '0; m_drop = '0; m_src = '0; m_ovr = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      rx_valid = 1'b1; rx_last = 1'b1;
      #1;
      n_cmp++;
      if (rx_ready !== 1'b0 || out_valid !== 2'b00) begin
         n_bad++;
         $display("FAIL post_reset_idle: rx_ready=%b out_valid=%b want 0/00", rx_ready, out_valid);
      end
      rx_valid = 1'b0; rx_last = 1'b0;
      run_frame(LMAC, 48'hF1F2_F3F4_F5F6, 16'h0800, 5, 2, 1'b1, -1);
   endtask

   initial begin
      test_reset();
      test_ipv4_local();
      test_arp_broadcast();
      test_drop_unicast();
      test_random_frames();
      test_overrun_drop();
      test_overrun_last();
      test_saturation();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ethertype_dispatcher.md
ETHERTYPE_DISPATCHER -- requirements
Module: ethertype_dispatcher

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, station MAC accepted as unicast destination.
REQ-002 SHALL have parameter TYPE_IPV4, default 16'h0800, ethertype routed to sink 0.
REQ-003 SHALL have parameter TYPE_ARP, default 16'h0806, ethertype routed to sink 1.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 hdr_valid  input  1  one-cycle pulse; header fields valid.
REQ-007 hdr_dst_mac  input  48  destination MAC of the frame.
REQ-008 hdr_src_mac  input  48  source MAC of the frame.
REQ-009 hdr_ethertype  input  16  ethertype of the frame.
REQ-010 rx_data / rx_valid / rx_last / rx_err  input  8/1/1/1  payload byte stream from ethernet_rx; rx_err qualifies the rx_last beat (FCS fail).
REQ-011 rx_ready  output  1  payload beat accepted when rx_valid & rx_ready.
REQ-012 out_data / out_last / out_err  output  8/1/1  shared payload bus to decoders.
REQ-013 out_valid  output  2  per-sink valid, bit 0 = IPv4, bit 1 = ARP; at most one bit high.
REQ-014 out_ready  input  2  per-sink ready.
REQ-015 out_src_mac  output  48  source MAC of the frame currently/last forwarded.
REQ-016 cnt_fwd / cnt_drop  output  16/16  forwarded / dropped frame counters.
REQ-017 hdr_overrun  output  1  sticky flag: header arrived while not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, FORWARD, DROP; reset state IDLE.
REQ-019 In IDLE, rx_ready SHALL be 0 and out_valid SHALL be 2'b00.
REQ-020 In IDLE on hdr_valid, frame SHALL match when (hdr_dst_mac == LOCAL_MAC or hdr_dst_mac == 48'hFFFF_FFFF_FFFF) and hdr_ethertype equals TYPE_IPV4 or TYPE_ARP.
REQ-021 On match SHALL latch sel (0 IPv4, 1 ARP) and hdr_src_mac into out_src_mac, next state FORWARD; on no match next state DROP, out_src_mac unchanged.
REQ-022 State change SHALL take effect the cycle after hdr_valid; first payload beat accepted no earlier than that cycle.
REQ-023 In FORWARD: out_data=rx_data, out_last=rx_last, out_err=rx_err combinationally (zero latency); out_valid[sel]=rx_valid, other bit 0; rx_ready=out_ready[sel].
REQ-024 In FORWARD, beat with rx_valid & rx_ready & rx_last SHALL return FSM to IDLE next cycle and increment cnt_fwd (rx_err frames still forwarded and counted in cnt_fwd).
REQ-025 In DROP: rx_ready=1, out_valid=0; beat with rx_valid & rx_last SHALL return to IDLE and increment cnt_drop.
REQ-026 Counters SHALL saturate at 16'hFFFF (no wrap).
REQ-027 hdr_valid in FORWARD or DROP SHALL be ignored (no state/sel/out_src_mac change) and SHALL set hdr_overrun; hdr_overrun clears only on reset.
REQ-028 hdr_valid coincident with final beat acceptance SHALL count as overrun (FSM not yet IDLE).
REQ-029 out_ready[~sel] SHALL have no effect in FORWARD.
REQ-030 Stall in FORWARD (out_ready[sel]=0) SHALL hold rx_ready=0 with no beat lost or duplicated.

Reset
REQ-031 Assertion of reset (low) SHALL asynchronously force: state IDLE, sel 0, out_src_mac 0, cnt_fwd 0, cnt_drop 0, hdr_overrun 0; hence rx_ready 0, out_valid 0.
REQ-032 Reset mid-frame SHALL abandon the frame without counting it; after release FSM waits in IDLE for next hdr_valid.

Verification
REQ-033 Header dst=LOCAL_MAC, type 0x0800, 4-byte payload, out_ready=2'b11 -> out_valid=2'b01 for 4 beats, bytes identical, out_last on 4th, cnt_fwd=1, out_src_mac=hdr_src_mac.
REQ-034 Broadcast dst, type 0x0806, out_ready[1] toggling every cycle -> bytes delivered on out_valid[1] in order, none lost/duplicated, cnt_fwd increments once.
REQ-035 dst=02:00:00:00:00:02, type 0x0800, 3 bytes -> rx_ready=1 each beat, out_valid=0 throughout, cnt_drop=1, cnt_fwd unchanged.
REQ-036 Type 0x86DD to LOCAL_MAC, then second hdr_valid mid-frame -> frame dropped, hdr_overrun=1, second header ignored, FSM IDLE after rx_last.
REQ-037 cnt_drop preloaded to 16'hFFFF via 65535 dropped frames (or forced), one more drop -> stays 16'hFFFF.
REQ-038 reset pulsed low mid-FORWARD -> outputs immediately per REQ-031, next valid frame forwarded normally with cnt_fwd=1.
